// File: rtl/field_pkg.sv
// field_pkg: state encoding and address-width helper shared by the Game of Life field blocks.
package field_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} cfg_load_state_t;

    function automatic int adr_size(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/field_scan_counter.sv
// field_scan_counter: raster (x fastest, then y) cell counter with wrap at the field edge and a last-cell flag.
module field_scan_counter
    import field_pkg::*;
#(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3,
    localparam int X_ADR_SIZE = adr_size(FIELD_W),
    localparam int Y_ADR_SIZE = adr_size(FIELD_H)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_adv,
    output logic [X_ADR_SIZE-1:0] o_x,
    output logic [Y_ADR_SIZE-1:0] o_y,
    output logic                  o_last
);

    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    logic x_end;
    logic y_end;

    assign x_end  = o_x == X_LAST;
    assign y_end  = o_y == Y_LAST;
    assign o_last = x_end && y_end;

    // Wrapping on the explicit last index keeps non-power-of-2 sizes in range.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            o_x <= '0;
            o_y <= '0;
        end else if (i_adv) begin
            o_x <= x_end ? '0 : o_x + 1'b1;
            o_y <= x_end ? (y_end ? '0 : o_y + 1'b1) : o_y;
        end
    end

endmodule

// File: rtl/field_cfg_loader.sv
// field_cfg_loader: copies the start-up pattern from field_cfg_rom into the field, one ready/valid write per cell.
// Optional FIELD_CFG_LOADER_ABORT_EN adds i_abort to cancel a load in progress.
module field_cfg_loader
    import field_pkg::*;
#(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3,
    localparam int X_ADR_SIZE = adr_size(FIELD_W),
    localparam int Y_ADR_SIZE = adr_size(FIELD_H)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
`ifdef FIELD_CFG_LOADER_ABORT_EN
    input  logic                  i_abort,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic [X_ADR_SIZE-1:0] o_rom_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_rom_y_adr,
    input  logic                  i_rom_cell_state,
    output logic                  o_wr_en,
    output logic [X_ADR_SIZE-1:0] o_wr_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_wr_y_adr,
    output logic                  o_wr_cell_state,
    input  logic                  i_wr_ready
);

    cfg_load_state_t       state_q;
    cfg_load_state_t       state_d;
    logic                  abort;
    logic                  cnt_clr;
    logic                  cnt_adv;
    logic                  cnt_last;
    logic                  data_q;
    logic [X_ADR_SIZE-1:0] cnt_x;
    logic [Y_ADR_SIZE-1:0] cnt_y;

`ifdef FIELD_CFG_LOADER_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    field_scan_counter #(
        .FIELD_W(FIELD_W),
        .FIELD_H(FIELD_H)
    ) u_scan (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (cnt_clr),
        .i_adv (cnt_adv),
        .o_x   (cnt_x),
        .o_y   (cnt_y),
        .o_last(cnt_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= (state_q == FETCH) ? i_rom_cell_state : data_q;
        end
    end

    // Abort wins over start and over a completing handshake; counters hold on abort.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = i_start && !abort;
                state_d = cnt_clr ? FETCH : IDLE;
            end
            FETCH: state_d = abort ? IDLE : WRITE;
            WRITE: begin
                cnt_adv = i_wr_ready && !abort && !cnt_last;
                state_d = abort ? IDLE : (i_wr_ready ? (cnt_last ? DONE : FETCH) : WRITE);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy          = (state_q == FETCH) || (state_q == WRITE);
    assign o_done          = state_q == DONE;
    assign o_wr_en         = state_q == WRITE;
    assign o_rom_x_adr     = cnt_x;
    assign o_rom_y_adr     = cnt_y;
    assign o_wr_x_adr      = cnt_x;
    assign o_wr_y_adr      = cnt_y;
    assign o_wr_cell_state = data_q;

endmodule
